// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX line encoder.
//   tx_state_e  : encoder line-state enumeration
//   LINE_J      : idle/J line level on dout
//   DEF_*       : default parameter values
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      STUFF,
      EOP_SE0,
      EOP_J
   } tx_state_e;

   localparam logic        LINE_J           = 1'b1;
   localparam int unsigned DEF_DATA_W       = 8;
   localparam int unsigned DEF_STUFF_LEN    = 6;
   localparam int unsigned DEF_EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_line_encoder_if.sv
// Word handshake between the TX packet assembler (master) and the encoder (slave).
//   tx_data  : word to send, bit 0 first
//   tx_valid : tx_data/tx_last valid
//   tx_last  : word is the last of its packet
//   tx_ready : encoder accepts the word this cycle
interface usb_tx_line_encoder_if
   import usb_tx_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
);

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_last;
   logic              tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_last,
      output tx_ready
   );

endinterface

// File: rtl/usb_bit_stuffer.sv
// Counts consecutive transmitted 1s and requests a stuff bit when the run hits STUFF_LEN.
//   clk, rst_b   : clock, async active-low reset
//   data_adv     : a data bit is driven on this edge
//   data_bit     : value of that data bit
//   restart      : first bit of a packet; count starts from zero
//   stuff_adv    : a stuff bit is driven on this edge (clears the run)
//   stuff_req_c  : combinational; the bit driven now completes a STUFF_LEN run
module usb_bit_stuffer
   import usb_tx_pkg::*;
#(
   parameter int unsigned STUFF_LEN = DEF_STUFF_LEN
) (
   input  logic clk,
   input  logic rst_b,
   input  logic data_adv,
   input  logic data_bit,
   input  logic restart,
   input  logic stuff_adv,
   output logic stuff_req_c
);

   localparam int unsigned CW = $clog2(STUFF_LEN + 1);

   logic [CW-1:0] ones;
   logic [CW-1:0] ones_base;
   logic [CW-1:0] ones_nxt;

   // Run length after the bit currently being driven.
   always_comb begin
      ones_base   = restart ? '0 : ones;
      ones_nxt    = data_bit ? ones_base + CW'(1) : '0;
      stuff_req_c = data_adv && (ones_nxt == CW'(STUFF_LEN));
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ones <= '0;
      end else if (data_adv) begin
         ones <= ones_nxt;
      end else if (stuff_adv) begin
         ones <= '0;
      end
   end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: serialises handshaked words LSB first, inserts stuff
// zeros, NRZI-encodes and frames each packet with SE0 x EOP_SE0_BITS then J.
//   clk, rst_b : clock, async active-low reset
//   bit_en     : one-cycle strobe per bit time; line state advances only on it
//   tx         : word handshake (slave side)
//   dout       : NRZI line level (1 = J)
//   se0        : drive SE0, overrides dout at the driver
//   oe         : driver output enable
//   underrun   : one-cycle pulse when a packet is aborted for lack of data
module usb_tx_line_encoder
   import usb_tx_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned STUFF_LEN    = DEF_STUFF_LEN,
   parameter int unsigned EOP_SE0_BITS = DEF_EOP_SE0_BITS
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  bit_en,
   usb_tx_line_encoder_if.slave  tx,
   output logic                  dout,
   output logic                  se0,
   output logic                  oe,
   output logic                  underrun
);

   localparam int unsigned BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned ECW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

   tx_state_e          state;
   logic [DATA_W-1:0]  sh;
   logic [BCW-1:0]     bit_cnt;
   logic               cur_last;
   logic               sh_valid;
   logic [DATA_W-1:0]  hold_data;
   logic               hold_last;
   logic               hold_valid;
   logic [ECW-1:0]     eop_cnt;

   logic [DATA_W-1:0]  src_word_c;
   logic [BCW-1:0]     src_idx_c;
   logic               src_last_c;
   logic               data_bit_c;
   logic               final_c;
   logic               start_c;
   logic               data_adv_c;
   logic               stuff_adv_c;
   logic               reload_c;
   logic               stuff_req_c;

   // Ready depends only on registered state.
   assign tx.tx_ready = !hold_valid && (state != EOP_SE0) && (state != EOP_J);

   // The bit driven on this edge comes from the holding register when a packet
   // starts, otherwise from the shift register.
   always_comb begin
      src_word_c = sh;
      src_idx_c  = bit_cnt;
      src_last_c = cur_last;
      if (state == IDLE) begin
         src_word_c = hold_data;
         src_idx_c  = '0;
         src_last_c = hold_last;
      end
      data_bit_c  = src_word_c[0];
      final_c     = (src_idx_c == BCW'(DATA_W - 1));
      start_c     = bit_en && (state == IDLE) && hold_valid;
      data_adv_c  = start_c || (bit_en && (state == DATA));
      stuff_adv_c = bit_en && (state == STUFF);
      // Next word of the same packet is loaded on the edge that drives the final bit.
      reload_c    = (state == DATA) && final_c && !src_last_c && hold_valid;
   end

   usb_bit_stuffer #(
      .STUFF_LEN (STUFF_LEN)
   ) u_stuffer (
      .clk         (clk),
      .rst_b       (rst_b),
      .data_adv    (data_adv_c),
      .data_bit    (data_bit_c),
      .restart     (start_c),
      .stuff_adv   (stuff_adv_c),
      .stuff_req_c (stuff_req_c)
   );

   // Line FSM, shift/holding registers and registered line outputs.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= IDLE;
         sh         <= '0;
         bit_cnt    <= '0;
         cur_last   <= 1'b0;
         sh_valid   <= 1'b0;
         hold_data  <= '0;
         hold_last  <= 1'b0;
         hold_valid <= 1'b0;
         eop_cnt    <= '0;
         dout       <= LINE_J;
         se0        <= 1'b0;
         oe         <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;

         if (tx.tx_valid && tx.tx_ready) begin
            hold_data  <= tx.tx_data;
            hold_last  <= tx.tx_last;
            hold_valid <= 1'b1;
         end

         if (data_adv_c) begin
            // A 0 toggles the line, a 1 holds it.
            dout     <= data_bit_c ? dout : ~dout;
            se0      <= 1'b0;
            oe       <= 1'b1;
            sh       <= src_word_c >> 1;
            bit_cnt  <= final_c ? '0 : src_idx_c + BCW'(1);
            cur_last <= src_last_c;
            sh_valid <= !final_c || reload_c;
            if (start_c) begin
               hold_valid <= 1'b0;
            end
            if (reload_c) begin
               sh         <= hold_data;
               cur_last   <= hold_last;
               hold_valid <= 1'b0;
            end
            if (stuff_req_c) begin
               state <= STUFF;
            end else if (!final_c || reload_c) begin
               state <= DATA;
            end else begin
               state    <= EOP_SE0;
               underrun <= !src_last_c;
            end
         end else if (bit_en) begin
            case (state)
               IDLE: begin
                  dout <= LINE_J;
                  se0  <= 1'b0;
                  oe   <= 1'b0;
               end
               STUFF: begin
                  dout <= ~dout;
                  if (sh_valid) begin
                     state <= DATA;
                  end else if (cur_last) begin
                     state <= EOP_SE0;
                  end else if (hold_valid) begin
                     sh         <= hold_data;
                     cur_last   <= hold_last;
                     bit_cnt    <= '0;
                     sh_valid   <= 1'b1;
                     hold_valid <= 1'b0;
                     state      <= DATA;
                  end else begin
                     underrun <= 1'b1;
                     state    <= EOP_SE0;
                  end
               end
               EOP_SE0: begin
                  se0 <= 1'b1;
                  oe  <= 1'b1;
                  if (eop_cnt == ECW'(EOP_SE0_BITS - 1)) begin
                     eop_cnt <= '0;
                     state   <= EOP_J;
                  end else begin
                     eop_cnt <= eop_cnt + ECW'(1);
                  end
               end
               EOP_J: begin
                  se0   <= 1'b0;
                  dout  <= LINE_J;
                  oe    <= 1'b1;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed self-checking bench for usb_tx_line_encoder (DATA_W=8, STUFF_LEN=6, EOP_SE0_BITS=2).
module tb_usb_tx_line_encoder;

   localparam int unsigned DATA_W = 8;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic bit_en = 1'b0;
   logic dout;
   logic se0;
   logic oe;
   logic underrun;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   usb_tx_line_encoder_if #(.DATA_W(DATA_W)) tx_if ();

   usb_tx_line_encoder #(
      .DATA_W       (DATA_W),
      .STUFF_LEN    (6),
      .EOP_SE0_BITS (2)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .bit_en   (bit_en),
      .tx       (tx_if),
      .dout     (dout),
      .se0      (se0),
      .oe       (oe),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bit time: gap idle clocks, then a single bit_en cycle; sampled on the following negedge.
   task automatic step(input string tag, input int gap, input int e_dout,
                       input logic e_se0, input logic e_oe, input logic e_und);
      repeat (gap) @(negedge clk);
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      if (e_dout >= 0) chk({tag, " dout"}, 32'(dout), 32'(e_dout));
      chk({tag, " se0"}, 32'(se0), 32'(e_se0));
      chk({tag, " oe"}, 32'(oe), 32'(e_oe));
      chk({tag, " underrun"}, 32'(underrun), 32'(e_und));
   endtask

   // n data/stuff bit times; lv[i] is the expected line level after the i-th bit_en.
   task automatic send_levels(input string tag, input int gap, input int n, input logic [15:0] lv);
      for (int i = 0; i < n; i++) begin
         step($sformatf("%s b%0d", tag, i), gap, int'(lv[i]), 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic push(input string tag, input logic [7:0] data, input logic last);
      chk({tag, " ready"}, 32'(tx_if.tx_ready), 32'd1);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = data;
      tx_if.tx_last  = last;
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
      chk({tag, " held"}, 32'(tx_if.tx_ready), 32'd0);
   endtask

   // SE0, SE0, J, then idle with oe low; poke offers a word while ready is low.
   task automatic eop(input string tag, input int gap, input logic poke);
      step({tag, " se0a"}, gap, -1, 1'b1, 1'b1, 1'b0);
      chk({tag, " rdy se0a"}, 32'(tx_if.tx_ready), 32'd0);
      if (poke) begin
         tx_if.tx_valid = 1'b1;
         tx_if.tx_data  = 8'h00;
         tx_if.tx_last  = 1'b1;
         @(negedge clk);
         tx_if.tx_valid = 1'b0;
      end
      step({tag, " se0b"}, gap, -1, 1'b1, 1'b1, 1'b0);
      chk({tag, " rdy se0b"}, 32'(tx_if.tx_ready), 32'd0);
      step({tag, " j"}, gap, 1, 1'b0, 1'b1, 1'b0);
      chk({tag, " rdy j"}, 32'(tx_if.tx_ready), 32'd1);
      step({tag, " idle"}, gap, 1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = '0;
      tx_if.tx_last  = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst dout", 32'(dout), 32'd1);
      chk("rst se0", 32'(se0), 32'd0);
      chk("rst oe", 32'(oe), 32'd0);
      chk("rst ready", 32'(tx_if.tx_ready), 32'd1);
      chk("rst underrun", 32'(underrun), 32'd0);
      rst_b = 1'b1;
      @(negedge clk);

      // Single word 0x80 last: KJKJKJKK, EOP; a word offered during EOP is ignored
      push("t1", 8'h80, 1'b1);
      chk("t1 no same-edge oe", 32'(oe), 32'd0);
      send_levels("t1", 3, 8, 16'h002A);
      eop("t1", 3, 1'b1);
      step("t1 ignored", 3, 1, 1'b0, 1'b0, 1'b0);

      // 0x80 then 0xFF last back to back; run of ones carries across words
      push("t2a", 8'h80, 1'b0);
      step("t2 start", 3, 0, 1'b0, 1'b1, 1'b0);
      push("t2b", 8'hFF, 1'b1);
      send_levels("t2", 3, 16, 16'hF015);
      eop("t2", 3, 1'b0);

      // 0x3F last: stuff after bit 5, then remaining zeros
      push("t3", 8'h3F, 1'b1);
      send_levels("t3", 3, 9, 16'h00BF);
      eop("t3", 3, 1'b0);

      // 0xFC last: six trailing ones, stuff bit precedes EOP
      push("t3b", 8'hFC, 1'b1);
      send_levels("t3b", 3, 9, 16'h00FE);
      eop("t3b", 3, 1'b0);

      // 0x55 non-last with no follow-up: underrun pulse, then EOP
      push("t4", 8'h55, 1'b0);
      send_levels("t4", 3, 7, 16'h0019);
      step("t4 final", 3, 1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4 pulse end", 32'(underrun), 32'd0);
      eop("t4", 3, 1'b0);

      // 0x0F last with bit_en low for 20 clocks mid-word, then back-to-back strobes
      push("t5", 8'h0F, 1'b1);
      send_levels("t5a", 3, 3, 16'h0007);
      repeat (20) @(negedge clk);
      chk("t5 frz dout", 32'(dout), 32'd1);
      chk("t5 frz se0", 32'(se0), 32'd0);
      chk("t5 frz oe", 32'(oe), 32'd1);
      chk("t5 frz ready", 32'(tx_if.tx_ready), 32'd1);
      send_levels("t5b", 0, 5, 16'h0015);
      eop("t5", 0, 1'b0);

      // Reset mid-DATA, then a fresh packet 0x03 last
      push("t6a", 8'hFF, 1'b1);
      send_levels("t6a", 3, 4, 16'h000F);
      #2;
      rst_b = 1'b0;
      #1;
      chk("t6 rst dout", 32'(dout), 32'd1);
      chk("t6 rst oe", 32'(oe), 32'd0);
      chk("t6 rst se0", 32'(se0), 32'd0);
      chk("t6 rst ready", 32'(tx_if.tx_ready), 32'd1);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      push("t6b", 8'h03, 1'b1);
      send_levels("t6b", 3, 8, 16'h00AB);
      eop("t6b", 3, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
